piezo_tone_gen: RTL and testbench

- Downstream sound stage of the main controller.
- Accepts note codes through a valid/ready handshake.
- Drives the piezo pin with a square wave at the note's pitch for a fixed duration, then holds an inter-note silence.
- Pitch half-periods are computed at elaboration from the system clock frequency.

---
 rtl/piezo_tone_gen.sv | 125 ++++++++++++
 tb/tb_piezo_tone_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_tone_gen.sv
// Note player for the piezo sound stage: accepts a note code, plays a square
// wave at its pitch for DUR_CYC cycles, then holds GAP_CYC cycles of silence.
module piezo_tone_gen #(
    parameter int FRQ     = 1_000_000,
    parameter int DUR_CYC = 10_000,
    parameter int GAP_CYC = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] note_code,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       stop,
    output logic       piezo,
    output logic       busy,
    output logic       note_done,
    output logic [3:0] cur_note
);

    localparam int HP_MAX  = FRQ / (2 * 262);
    localparam int CNT_MAX = (DUR_CYC > GAP_CYC)
                           ? ((DUR_CYC > HP_MAX) ? DUR_CYC : HP_MAX)
                           : ((GAP_CYC > HP_MAX) ? GAP_CYC : HP_MAX);
    localparam int CW = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] DUR_LAST = CW'(DUR_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] dur_cnt;
    logic [CW-1:0] hp_cnt;
    logic [CW-1:0] hp_last;
    logic          done_nxt;

    function automatic logic [CW-1:0] hp_of(input logic [3:0] code);
        case (code)
            4'd1:    hp_of = CW'(FRQ / (2 * 262));
            4'd2:    hp_of = CW'(FRQ / (2 * 294));
            4'd3:    hp_of = CW'(FRQ / (2 * 330));
            4'd4:    hp_of = CW'(FRQ / (2 * 349));
            4'd5:    hp_of = CW'(FRQ / (2 * 392));
            4'd6:    hp_of = CW'(FRQ / (2 * 440));
            4'd7:    hp_of = CW'(FRQ / (2 * 494));
            4'd8:    hp_of = CW'(FRQ / (2 * 523));
            default: hp_of = '0;
        endcase
    endfunction

    assign hp_last    = hp_of(cur_note) - 1'b1;
    assign busy       = (state != IDLE);
    assign note_ready = (state == IDLE) & ~stop & ~rst;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (note_valid && note_ready) state_nxt = PLAY;
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (dur_cnt == DUR_LAST) begin
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                    done_nxt  = (GAP_CYC == 0);
                end
            end
            GAP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (dur_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_cnt   <= '0;
            hp_cnt    <= '0;
            piezo     <= 1'b0;
            note_done <= 1'b0;
            cur_note  <= '0;
        end else begin
            note_done <= done_nxt;
            if (state == IDLE) begin
                if (state_nxt == PLAY) begin
                    cur_note <= (note_code > 4'd8) ? 4'd0 : note_code;
                    dur_cnt  <= '0;
                    hp_cnt   <= '0;
                    piezo    <= 1'b0;
                end
            end else if (state_nxt != state) begin
                dur_cnt <= '0;
                hp_cnt  <= '0;
                piezo   <= 1'b0;
                if (state_nxt == IDLE) cur_note <= '0;
            end else begin
                dur_cnt <= dur_cnt + 1'b1;
                // Tone counter holds for the first PLAY cycle so the first
                // half-period spans HP+1 cycles from the accept edge.
                if (state == PLAY && cur_note != 4'd0 && dur_cnt != '0) begin
                    if (hp_cnt == hp_last) begin
                        hp_cnt <= '0;
                        piezo  <= ~piezo;
                    end else begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Scoreboard bench for piezo_tone_gen: expected note records are queued when a
// note is driven and compared against what the monitor measures per note.
module tb_piezo_tone_gen;

    localparam int FRQ   = 1_000_000;
    localparam int DUR   = 10_000;
    localparam int GAP   = 1_000;
    localparam int G_DUR = 200;
    localparam int BOUND = 30_000;

    typedef struct {
        int code;
        int busy_len;
        int done;
        int first;
        int period;
        int rises;
        int spacing;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] note_code = 4'd6;
    logic       note_valid = 1'b1;
    logic       stop = 1'b0;
    logic       note_ready, piezo, busy, note_done;
    logic [3:0] cur_note;

    logic [3:0] g_code = 4'd8;
    logic       g_valid = 1'b1;
    logic       g_stop = 1'b0;
    logic       g_ready, g_piezo, g_busy, g_done;
    logic [3:0] g_cur;

    int checks = 0;
    int fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    piezo_tone_gen #(.FRQ(FRQ), .DUR_CYC(DUR), .GAP_CYC(GAP)) u_dut (
        .clk(clk), .rst(rst), .note_code(note_code), .note_valid(note_valid),
        .note_ready(note_ready), .stop(stop), .piezo(piezo), .busy(busy),
        .note_done(note_done), .cur_note(cur_note)
    );

    piezo_tone_gen #(.FRQ(FRQ), .DUR_CYC(G_DUR), .GAP_CYC(0)) u_g0 (
        .clk(clk), .rst(rst), .note_code(g_code), .note_valid(g_valid),
        .note_ready(g_ready), .stop(g_stop), .piezo(g_piezo), .busy(g_busy),
        .note_done(g_done), .cur_note(g_cur)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int freq(input int code);
        case (code)
            1: return 262;  2: return 294;  3: return 330;  4: return 349;
            5: return 392;  6: return 440;  7: return 494;  default: return 523;
        endcase
    endfunction

    function automatic exp_t mk(input int code, input int len, input int done, input int spacing);
        exp_t e;
        int hp, lim, t;
        e.code = (code >= 1 && code <= 8) ? code : 0;
        e.busy_len = len;  e.done = done;  e.spacing = spacing;
        e.rises = 0;  e.first = -1;  e.period = -1;
        if (e.code != 0) begin
            hp  = FRQ / (2 * freq(e.code));
            lim = ((len < DUR) ? len : DUR) - 1;
            t   = hp + 1;
            while (t <= lim) begin
                e.rises++;
                t += 2 * hp;
            end
            if (e.rises >= 1) e.first = hp + 1;
            if (e.rises >= 2) e.period = 2 * hp;
        end
        return e;
    endfunction

    // Monitor: sample index c counts samples after the accept edge (c=0 first PLAY sample).
    int n = 0, acc = 0, last_acc = -1, spacing = -1;
    bit in_note = 1'b0, pz_q = 1'b0;
    int busy_len, first, second, rises, cur_first, cur_bad, stray = 0;

    always @(negedge clk) begin
        int c;
        exp_t e;
        n++;
        c = n - acc - 1;
        if (in_note) begin
            if (busy) begin
                if (busy_len == 0) cur_first = int'(cur_note);
                else if (int'(cur_note) != cur_first) cur_bad++;
                busy_len++;
                if (piezo && !pz_q) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                    rises++;
                end
                if (note_done) stray++;
            end else begin
                in_note = 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("cur_note", cur_first, e.code);
                    chk("cur_stable", cur_bad, 0);
                    chk("busy_len", busy_len, e.busy_len);
                    chk("note_done", int'(note_done), e.done);
                    chk("first_rise", first, e.first);
                    chk("period", (second >= 0) ? second - first : -1, e.period);
                    chk("rises", rises, e.rises);
                    chk("piezo_end", int'(piezo), 0);
                    chk("cur_idle", int'(cur_note), 0);
                    if (e.spacing >= 0) chk("spacing", spacing, e.spacing);
                end
            end
        end else if (note_done) begin
            stray++;
        end
        pz_q = piezo;
        if (note_valid && note_ready) begin
            spacing  = (last_acc >= 0) ? n - last_acc : -1;
            acc      = n;
            last_acc = n;
            in_note  = 1'b1;
            busy_len = 0;  first = -1;  second = -1;  rises = 0;
            cur_first = -1;  cur_bad = 0;
        end
    end

    task automatic wait_acc(input string tag);
        int k = 0;
        while (!(note_valid && note_ready) && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (k >= BOUND) chk(tag, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < BOUND);
        if (k >= BOUND) chk(tag, 0, 1);
    endtask

    initial begin
        fork
            begin
                sb.push_back(mk(6, DUR + GAP, 1, -1));
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("rst_piezo", int'(piezo), 0);
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_ready", int'(note_ready), 0);
                end
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("ready_after_rst", int'(note_ready), 1);
                wait_acc("to_a4");
                note_valid = 1'b0;
                wait_idle("to_a4_end");

                @(posedge clk); #1;
                stop = 1'b1;  note_valid = 1'b1;  note_code = 4'd2;
                @(negedge clk);
                chk("stop_idle_ready", int'(note_ready), 0);
                @(posedge clk); #1;
                stop = 1'b0;  note_valid = 1'b0;
                @(negedge clk);
                chk("stop_idle_noacc", int'(busy), 0);

                sb.push_back(mk(0, DUR + GAP, 1, -1));
                note_code = 4'd0;  note_valid = 1'b1;
                wait_acc("to_rest");
                note_valid = 1'b0;
                wait_idle("to_rest_end");

                sb.push_back(mk(12, DUR + GAP, 1, -1));
                note_code = 4'd12;  note_valid = 1'b1;
                wait_acc("to_c12");
                note_valid = 1'b0;
                wait_idle("to_c12_end");

                sb.push_back(mk(1, DUR + GAP, 1, -1));
                sb.push_back(mk(8, DUR + GAP, 1, DUR + GAP + 1));
                note_code = 4'd1;  note_valid = 1'b1;
                wait_acc("to_b2b1");
                note_code = 4'd8;
                wait_acc("to_b2b2");
                note_valid = 1'b0;
                wait_idle("to_b2b_end");

                sb.push_back(mk(3, 3000, 0, -1));
                sb.push_back(mk(5, 10500, 0, 3001));
                note_code = 4'd3;  note_valid = 1'b1;
                wait_acc("to_stop_note");
                note_valid = 1'b0;
                repeat (2999) @(posedge clk);
                #1 stop = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;  note_code = 4'd5;  note_valid = 1'b1;
                wait_acc("to_after_stop");
                note_valid = 1'b0;
                // Assert reset so it lands on the 10500th edge, inside GAP.
                repeat (10499) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                repeat (3) @(negedge clk);
                chk("sb_left", sb.size(), 0);
                chk("stray_done", stray, 0);
            end
            begin
                int a1 = -1, a2 = -1, dn = -1;
                for (int i = 0; i < 2000 && a2 < 0; i++) begin
                    @(negedge clk);
                    if (g_done && dn < 0 && a1 >= 0) dn = i - a1 - 1;
                    if (g_valid && g_ready) begin
                        if (a1 < 0) a1 = i;
                        else a2 = i;
                    end
                end
                g_valid = 1'b0;
                // Done is visible in the first IDLE cycle, closing at accept edge + DUR + 1.
                chk("g0_done_lat", dn, G_DUR);
                chk("g0_spacing", (a1 >= 0 && a2 >= 0) ? a2 - a1 : -1, G_DUR + 1);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
